// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic pipeline stage register. It replaces the fixed IF/ID, ID/EX,
// EX/MEM and MEM/WB registers of the pipelined core with one block. The block
// carries a control bundle and a data bundle across a valid/ready handshake.
// A second (skid) entry absorbs one cycle of backpressure, so in_ready is
// decoded from state registers only and never depends on out_ready in the
// same cycle. A synchronous flush squashes every held entry and turns the
// stage into a bubble, which is how branch and jump squash is done.
//
// Parameters:
//   DATA_W    width of the data bundle
//   CTRL_W    width of the control bundle
//   CTRL_RST  control value shown while no valid entry is held; it must
//             encode "no architectural side effect"
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   flush       synchronous squash of all held entries
//   in_valid    upstream entry valid
//   in_ready    stage can accept an entry this cycle
//   in_ctrl     upstream control bundle
//   in_data     upstream data bundle
//   out_valid   output entry valid
//   out_ready   downstream accepts this cycle
//   out_ctrl    control bundle, CTRL_RST while out_valid is low
//   out_data    data bundle, keeps its last value while out_valid is low
//   stall_cnt   saturating count of cycles with out_valid & !out_ready
//   bubble_cnt  saturating count of cycles with !out_valid
//
// Optional feature macro: PIPE_STAGE_PERF_EN
//   Defined: stall_cnt and bubble_cnt exist. Only rst clears them.
//   Undefined: both counters and both ports are absent.
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int                 DATA_W   = 32,
  parameter int                 CTRL_W   = 8,
  parameter logic [CTRL_W-1:0]  CTRL_RST = {CTRL_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  // EMPTY: nothing held. FULL: the main entry is presented downstream.
  // SKID: main is presented and a second entry waits behind it.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } stateT;

  stateT             state;
  logic [CTRL_W-1:0] mainCtrl;
  logic [DATA_W-1:0] mainData;
  logic [CTRL_W-1:0] skidCtrl;
  logic [DATA_W-1:0] skidData;
  logic              inFire;
  logic              outFire;

  // Both handshake flags are decoded from the state register only. This
  // keeps the upstream ready path free of any combinational dependence on
  // out_ready. The output bundle comes straight from the main entry
  // registers, and the main control field is reloaded with CTRL_RST whenever
  // the stage empties.
  assign in_ready  = (state != SKID);
  assign out_valid = (state != EMPTY);
  assign out_ctrl  = mainCtrl;
  assign out_data  = mainData;
  assign inFire    = in_valid & in_ready;
  assign outFire   = out_valid & out_ready;

  // Main state machine and entry storage. Flush wins over every transfer:
  // an entry offered in the flush cycle is dropped, and any entry that
  // downstream takes in that cycle is simply gone. mainData is left as it
  // is on flush, so out_data keeps showing the last value. The skid entry
  // is cleared whenever it is dropped or moved forward, so a stale entry
  // can never come back later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      mainCtrl <= CTRL_RST;
      mainData <= '0;
      skidCtrl <= CTRL_RST;
      skidData <= '0;
    end else if (flush) begin
      state    <= EMPTY;
      mainCtrl <= CTRL_RST;
      skidCtrl <= CTRL_RST;
      skidData <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (inFire) begin
            mainCtrl <= in_ctrl;
            mainData <= in_data;
            state    <= FULL;
          end
        end
        FULL: begin
          if (outFire && inFire) begin
            mainCtrl <= in_ctrl;
            mainData <= in_data;
          end else if (outFire) begin
            mainCtrl <= CTRL_RST;
            state    <= EMPTY;
          end else if (inFire) begin
            skidCtrl <= in_ctrl;
            skidData <= in_data;
            state    <= SKID;
          end
        end
        SKID: begin
          if (outFire) begin
            mainCtrl <= skidCtrl;
            mainData <= skidData;
            skidCtrl <= CTRL_RST;
            skidData <= '0;
            state    <= FULL;
          end
        end
        default: begin
          mainCtrl <= CTRL_RST;
          state    <= EMPTY;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  // Performance counters. A stall is a cycle where a valid output waits on
  // downstream. A bubble is any cycle with no valid output. Both counters
  // stop at all-ones instead of wrapping. Only rst clears them. Flush does
  // not, so a squash does not hide the stalls that came before it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (!out_valid && (bubble_cnt != 32'hFFFF_FFFF)) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
